// File: rtl/aes_ctr_pkg.sv
// Shared constants for the AES-256-CTR keystream arbiter: FSM encoding,
// requester modes and per-request batch targets.
package aes_ctr_pkg;

  localparam int BLOCKS_PER_BATCH = 4;
  localparam int XOF_BLOCKS       = 44;
  localparam int PRF_BLOCKS       = 8;
  localparam int XOF_BATCHES      = XOF_BLOCKS / BLOCKS_PER_BATCH;
  localparam int PRF_BATCHES      = PRF_BLOCKS / BLOCKS_PER_BATCH;
  localparam int FIFO_DEPTH       = 2;
  localparam int CNT_W            = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam logic XOF_MODE = 1'b0;
  localparam logic PRF_MODE = 1'b1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LAUNCH  = 3'd1;
  localparam logic [2:0] ST_RUN     = 3'd2;
  localparam logic [2:0] ST_DRAIN   = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  // Number of 512-bit batches the engine produces for a request of this mode.
  function automatic cnt_t batch_target(input logic mode);
    return (mode == PRF_MODE) ? CNT_W'(PRF_BATCHES) : CNT_W'(XOF_BATCHES);
  endfunction

endpackage

// File: rtl/batch_fifo.sv
// Two-entry batch buffer. Slot 0 is always the head, so the data presented
// downstream comes straight from a register with no read mux.
module batch_fifo
  import aes_ctr_pkg::*;
#(
  parameter int BATCH_W = 512
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [BATCH_W-1:0] push_data,
  input  logic               pop,
  output logic [BATCH_W-1:0] head,
  output logic [1:0]         count
);

  logic [BATCH_W-1:0] slot0;
  logic [BATCH_W-1:0] slot1;
  logic               pop_ok;
  logic               push_ok;

  // A pop on an empty buffer is meaningless; a push into a full buffer is
  // dropped unless the head leaves in the same cycle.
  assign pop_ok  = pop && (count != 2'd0);
  assign push_ok = push && ((count != 2'(FIFO_DEPTH)) || pop_ok);
  assign head    = slot0;

  // Occupancy: simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
    end else if (push_ok && !pop_ok) begin
      count <= count + 2'd1;
    end else if (pop_ok && !push_ok) begin
      count <= count - 2'd1;
    end
  end

  // Payload slots shift toward the head on pop; new data lands behind the
  // youngest valid entry.
  always_ff @(posedge clk) begin
    case ({push_ok, pop_ok})
      2'b10: begin
        if (count == 2'd0) slot0 <= push_data;
        else               slot1 <= push_data;
      end
      2'b01: slot0 <= slot1;
      2'b11: begin
        if (count == 2'd1) begin
          slot0 <= push_data;
        end else begin
          slot0 <= slot1;
          slot1 <= push_data;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/aes_ctr_stream_arbiter.sv
// Shares one 4-lane AES-256-CTR keystream engine between an XOF requester
// (port 0) and a PRF requester (port 1). Round-robin arbitration, nonce
// latching, engine launch, batch buffering with engine hold, and release.
module aes_ctr_stream_arbiter
  import aes_ctr_pkg::*;
#(
  parameter int BATCH_W = 512
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req,
  input  logic [7:0]         nonce_a0,
  input  logic [7:0]         nonce_b0,
  input  logic [7:0]         nonce_a1,
  input  logic [7:0]         nonce_b1,
  output logic [1:0]         gnt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BATCH_W-1:0] out_data,
  output logic               out_last,
  output logic [1:0]         done,
  output logic               eng_start,
  output logic               eng_mode,
  output logic [7:0]         eng_nonce_a,
  output logic [7:0]         eng_nonce_b,
  output logic               eng_hold,
  input  logic               eng_batch_valid,
  input  logic [BATCH_W-1:0] eng_batch
);

  logic [2:0] state;
  logic       rr_ptr;
  logic       winner;
  logic       pick;
  cnt_t       prod_cnt;
  cnt_t       cons_cnt;
  cnt_t       target;
  logic [1:0] fifo_count;
  logic       push;
  logic       pop;
  logic       err_stray;

  // Port index doubles as engine mode: port 0 is XOF, port 1 is PRF.
  assign pick   = (req == 2'b11) ? rr_ptr : req[1];
  assign target = batch_target(eng_mode);

  // Only batches arriving while the engine is legitimately running are kept.
  assign push      = (state == ST_RUN) && eng_batch_valid;
  assign out_valid = (fifo_count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_last  = out_valid && (cons_cnt == (target - 4'd1));

  // Holding the engine whenever anything is buffered guarantees a free slot
  // for the batch it is allowed to produce next.
  assign eng_hold  = (state == ST_RUN) && (fifo_count != 2'd0);
  assign eng_start = (state == ST_LAUNCH);
  assign done      = (state == ST_RELEASE) ? {winner, ~winner} : 2'b00;

  batch_fifo #(
    .BATCH_W (BATCH_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (eng_batch),
    .pop       (pop),
    .head      (out_data),
    .count     (fifo_count)
  );

  // Request lifecycle: arbitrate, launch, collect batches, drain, release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rr_ptr      <= 1'b0;
      winner      <= 1'b0;
      gnt         <= 2'b00;
      eng_mode    <= XOF_MODE;
      eng_nonce_a <= 8'd0;
      eng_nonce_b <= 8'd0;
      prod_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req != 2'b00) begin
            winner      <= pick;
            eng_mode    <= pick;
            eng_nonce_a <= pick ? nonce_a1 : nonce_a0;
            eng_nonce_b <= pick ? nonce_b1 : nonce_b0;
            gnt         <= pick ? 2'b10 : 2'b01;
            state       <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          prod_cnt <= '0;
          state    <= ST_RUN;
        end
        ST_RUN: begin
          if (eng_batch_valid) begin
            prod_cnt <= prod_cnt + 4'd1;
            if (prod_cnt == (target - 4'd1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (cons_cnt == target) begin
            gnt   <= 2'b00;
            state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          rr_ptr <= ~winner;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Batches handed to the requester; cleared at each launch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cons_cnt <= '0;
    end else if (state == ST_LAUNCH) begin
      cons_cnt <= '0;
    end else if (pop) begin
      cons_cnt <= cons_cnt + 4'd1;
    end
  end

  // Sticky debug flag: engine strobed when no request was running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_stray <= 1'b0;
    end else if (eng_batch_valid && (state != ST_RUN)) begin
      err_stray <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_ctr_stream_arbiter.sv
// Directed bench for aes_ctr_stream_arbiter: table of request vectors plus
// hand-written stray-strobe and mid-request reset sequences.
module tb_aes_ctr_stream_arbiter;
  import aes_ctr_pkg::*;

  localparam int BW = 512;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [1:0]    req = 2'b00;
  logic [7:0]    nonce_a0 = 8'd0, nonce_b0 = 8'd0, nonce_a1 = 8'd0, nonce_b1 = 8'd0;
  logic [1:0]    gnt;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [BW-1:0] out_data;
  logic          out_last;
  logic [1:0]    done;
  logic          eng_start;
  logic          eng_mode;
  logic [7:0]    eng_nonce_a, eng_nonce_b;
  logic          eng_hold;
  logic          eng_batch_valid;
  logic [BW-1:0] eng_batch;

  aes_ctr_stream_arbiter #(.BATCH_W(BW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req             (req),
    .nonce_a0        (nonce_a0),
    .nonce_b0        (nonce_b0),
    .nonce_a1        (nonce_a1),
    .nonce_b1        (nonce_b1),
    .gnt             (gnt),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_last        (out_last),
    .done            (done),
    .eng_start       (eng_start),
    .eng_mode        (eng_mode),
    .eng_nonce_a     (eng_nonce_a),
    .eng_nonce_b     (eng_nonce_b),
    .eng_hold        (eng_hold),
    .eng_batch_valid (eng_batch_valid),
    .eng_batch       (eng_batch)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference keystream batch: depends on mode, nonce pair and batch index.
  function automatic logic [BW-1:0] mk_batch(input logic mode, input logic [7:0] na,
                                             input logic [7:0] nb, input int idx);
    logic [BW-1:0] b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = {na, nb, 8'(idx), 4'(i), 3'h5, mode};
    return b;
  endfunction

  // Engine model: launched by eng_start, one batch per free slot.
  logic       eng_ignore_hold = 1'b0;
  logic       stray_req = 1'b0;
  int         eng_left = 0;
  int         eng_idx = 0;
  logic       eng_m = 1'b0;
  logic [7:0] eng_a = 8'd0, eng_b = 8'd0;

  initial begin
    eng_batch_valid = 1'b0;
    eng_batch = '0;
    forever begin
      @(negedge clk);
      eng_batch_valid = 1'b0;
      if (!rst_n) begin
        eng_left = 0;
      end else if (stray_req) begin
        stray_req = 1'b0;
        eng_batch_valid = 1'b1;
        eng_batch = '1;
      end else if (eng_start) begin
        eng_left = eng_mode ? PRF_BATCHES : XOF_BATCHES;
        eng_idx = 0;
        eng_m = eng_mode;
        eng_a = eng_nonce_a;
        eng_b = eng_nonce_b;
      end else if (eng_left > 0 && (!eng_hold || eng_ignore_hold)) begin
        eng_batch_valid = 1'b1;
        eng_batch = mk_batch(eng_m, eng_a, eng_b, eng_idx);
        eng_idx++;
        eng_left--;
      end
    end
  end

  // Push into a full buffer with no concurrent pop must never occur.
  int overflow = 0;
  always @(posedge clk) begin
    if (rst_n && eng_batch_valid && dut.state == ST_RUN && dut.fifo_count == 2'd2 &&
        !(out_valid && out_ready))
      overflow++;
  end

  typedef struct {
    logic [1:0] req;
    logic [7:0] na0, nb0, na1, nb1;
    logic       keep_req;
    int         stall;
    logic       ignore_hold;
    logic       chk_hold1;
    logic [1:0] exp_gnt;
    logic       exp_mode;
    logic [7:0] exp_na, exp_nb;
    int         exp_batches;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    int wait_cyc, n_out, stall_left, starts, hold_run, hold_max, hold_bad, cnt_bad, guard;
    logic [1:0] done_seen;
    nonce_a0 = v.na0; nonce_b0 = v.nb0; nonce_a1 = v.na1; nonce_b1 = v.nb1;
    eng_ignore_hold = v.ignore_hold;
    out_ready = 1'b1;
    req = v.req;
    wait_cyc = 0;
    do begin
      @(negedge clk);
      wait_cyc++;
    end while (!eng_start && wait_cyc < 50);
    chk({tag, "_start_latency"}, wait_cyc, 1);
    chk({tag, "_gnt"}, gnt, v.exp_gnt);
    chk({tag, "_mode"}, eng_mode, v.exp_mode);
    chk({tag, "_nonce_a"}, eng_nonce_a, v.exp_na);
    chk({tag, "_nonce_b"}, eng_nonce_b, v.exp_nb);
    n_out = 0; stall_left = v.stall; starts = 0; hold_run = 0; hold_max = 0;
    hold_bad = 0; cnt_bad = 0; guard = 0; done_seen = 2'b00;
    while (done_seen == 2'b00 && guard < 400) begin
      @(negedge clk);
      guard++;
      if (eng_start) starts++;
      if (eng_hold) hold_run++; else hold_run = 0;
      if (hold_run > hold_max) hold_max = hold_run;
      if (out_valid && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
        if (!eng_hold || dut.fifo_count > 2'd2) hold_bad++;
      end else begin
        out_ready = 1'b1;
      end
      if (v.ignore_hold && out_valid && dut.fifo_count != 2'd1) cnt_bad++;
      if (out_valid && out_ready) begin
        chk($sformatf("%s_data%0d", tag, n_out), out_data,
            mk_batch(v.exp_mode, v.exp_na, v.exp_nb, n_out));
        chk($sformatf("%s_last%0d", tag, n_out), out_last, n_out == v.exp_batches - 1);
        n_out++;
      end
      done_seen = done;
      if (done != 2'b00) begin
        chk({tag, "_done"}, done, v.exp_gnt);
        chk({tag, "_gnt_at_done"}, gnt, 2'b00);
      end
    end
    if (!v.keep_req) req = 2'b00;
    out_ready = 1'b1;
    chk({tag, "_done_seen"}, done_seen != 2'b00, 1);
    chk({tag, "_batches"}, n_out, v.exp_batches);
    chk({tag, "_extra_start"}, starts, 0);
    if (v.stall > 0) chk({tag, "_stall_hold"}, hold_bad, 0);
    if (v.chk_hold1) chk({tag, "_hold_run_max"}, hold_max, 1);
    if (v.ignore_hold) chk({tag, "_pushpop_count"}, cnt_bad, 0);
    @(negedge clk);
    chk({tag, "_done_width"}, done, 2'b00);
    chk({tag, "_err_stray"}, dut.err_stray, 1'b0);
  endtask

  vec_t vecs[7];
  vec_t after_rst;

  initial begin
    int n, guard;
    //          req    na0    nb0    na1    nb1  keep stall ign  h1   gnt  mode   na     nb  batches
    vecs[0] = '{2'b11, 8'hA1, 8'hB1, 8'hA2, 8'hB2, 1'b1, 0, 1'b0, 1'b1, 2'b01, 1'b0, 8'hA1, 8'hB1, 11};
    vecs[1] = '{2'b11, 8'hA1, 8'hB1, 8'hA2, 8'hB2, 1'b1, 0, 1'b0, 1'b0, 2'b10, 1'b1, 8'hA2, 8'hB2, 2};
    vecs[2] = '{2'b11, 8'hA1, 8'hB1, 8'hA2, 8'hB2, 1'b0, 0, 1'b0, 1'b0, 2'b01, 1'b0, 8'hA1, 8'hB1, 11};
    vecs[3] = '{2'b10, 8'h00, 8'h00, 8'h12, 8'h34, 1'b0, 0, 1'b0, 1'b0, 2'b10, 1'b1, 8'h12, 8'h34, 2};
    vecs[4] = '{2'b01, 8'h9C, 8'h47, 8'h00, 8'h00, 1'b0, 0, 1'b0, 1'b1, 2'b01, 1'b0, 8'h9C, 8'h47, 11};
    vecs[5] = '{2'b10, 8'h00, 8'h00, 8'h3E, 8'h81, 1'b0, 20, 1'b0, 1'b0, 2'b10, 1'b1, 8'h3E, 8'h81, 2};
    vecs[6] = '{2'b01, 8'h66, 8'h99, 8'h00, 8'h00, 1'b0, 0, 1'b1, 1'b0, 2'b01, 1'b0, 8'h66, 8'h99, 11};
    after_rst = '{2'b10, 8'h00, 8'h00, 8'hE7, 8'h18, 1'b0, 0, 1'b0, 1'b0, 2'b10, 1'b1, 8'hE7, 8'h18, 2};

    #2 rst_n = 1'b0;
    #1;
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_done", done, 2'b00);
    chk("rst_eng_start", eng_start, 1'b0);
    chk("rst_eng_hold", eng_hold, 1'b0);
    chk("rst_eng_cfg", {eng_mode, eng_nonce_a, eng_nonce_b}, 17'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_out_last", out_last, 1'b0);
    chk("post_rst_fifo_count", dut.fifo_count, 2'd0);
    chk("post_rst_err_stray", dut.err_stray, 1'b0);

    for (int i = 0; i < 7; i++) begin
      eng_ignore_hold = 1'b0;
      run_vec(vecs[i], $sformatf("v%0d", i));
    end
    eng_ignore_hold = 1'b0;
    chk("overflow_events", overflow, 0);

    // Engine strobe while idle: dropped, flagged.
    stray_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("stray_flag", dut.err_stray, 1'b1);
    chk("stray_no_push", {out_valid, dut.fifo_count}, 3'd0);

    // Reset while the fifth XOF batch is in flight.
    nonce_a0 = 8'h5A; nonce_b0 = 8'hC3; out_ready = 1'b1; req = 2'b01;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!eng_start && guard < 50);
    n = 0;
    guard = 0;
    while (n < 4 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (out_valid && out_ready) n++;
    end
    @(negedge clk);
    chk("rst_mid_pre_gnt", gnt, 2'b01);
    chk("rst_mid_pre_nonce", {eng_nonce_a, eng_nonce_b}, 16'h5AC3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_gnt", gnt, 2'b00);
    chk("rst_mid_out", {out_valid, out_last, done, eng_start, eng_hold}, 6'd0);
    chk("rst_mid_eng_cfg", {eng_mode, eng_nonce_a, eng_nonce_b}, 17'd0);
    chk("rst_mid_fifo_count", dut.fifo_count, 2'd0);
    chk("rst_mid_state", dut.state, ST_IDLE);
    req = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_err_cleared", dut.err_stray, 1'b0);
    run_vec(after_rst, "after_rst");
    chk("final_overflow_events", overflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
